sseg_spi_rx: RTL
================

# sseg_spi_rx

Serial receiver for the 3-wire seven-segment display link (`sclk`, `load`, serial data): the responder end of the display driver's frames. It oversamples the link in the `clk` domain and shifts in 16-bit MSB-first frames. On each `load` rising edge it decodes the latched frame into an 8-digit segment image plus display control registers. It serves as the on-chip display model for regression benches and as the receive side for driving a remote display board from a second FPGA.

## Interface
Parameters:
- `FRAME_W`, 16: bits per frame; bits [11:8] are the address and bits [7:0] are the data.
- `DIGITS`, 8: number of digit registers.

Ports:
- `clk` input 1: system clock.
- `rst` input 1: reset, asynchronous and active-high.
- `sclk` input 1: serial clock, asynchronous to `clk`.
- `load` input 1: frame latch, asynchronous to `clk`; a frame is open while `load` is low.
- `sdi` input 1: serial data, MSB first.
- `seg` output 64: segment image; digit k (address k+1) drives `seg[8k+7:8k]`.
- `decode_mode` output 8: control register at address 0x9.
- `intensity` output 4: control register at address 0xA (data bits [3:0]).
- `scan_limit` output 3: control register at address 0xB (data bits [2:0]).
- `shutdown_n` output 1: control register at address 0xC (data bit 0); 0 means shutdown.
- `disp_test` output 1: control register at address 0xF (data bit 0).
- `frame_valid` output 1: one-cycle pulse for each accepted frame.
- `frame_err` output 1: one-cycle pulse for each rejected frame (only when `SSEG_RX_LEN_CHECK_EN` is defined).

## Operation
- `sclk`, `load` and `sdi` each pass through a 2-flop synchronizer followed by a delay flop. Edges are detected between the synchronizer output and the delay flop.
- **sclk rising edge with `load` low:**
  - shift register `sr <= {sr[14:0], sdi_sync}`;
  - bit counter `bcnt` increments and saturates at 31.
- **sclk edges with `load` high:** ignored.
- **load falling edge:** `bcnt <= 0`. The shift register is left as is.
- **load rising edge (commit):** the frame is decoded from `sr` as follows.
  - Address 0x0: no-op. No register changes; `frame_valid` still pulses.
  - Address 0x1–0x8: digit register (address − 1) takes `sr[7:0]`.
  - Address 0x9, 0xA, 0xB, 0xC, 0xF: the corresponding control register updates.
  - Address 0xD, 0xE: ignored; `frame_valid` pulses.
  - Bits [15:12] are don't-care.
- **sclk rising and load rising detected in the same cycle:** the commit uses `sr` as it was before the edge, and that sclk edge is discarded.
- **Reset values:**
  - `seg` = 0, `decode_mode` = 0, `intensity` = 0, `scan_limit` = 0, `disp_test` = 0;
  - `shutdown_n` = 0 (display starts in shutdown);
  - `frame_valid` = 0, `frame_err` = 0;
  - `sr` = 0, `bcnt` = 0, all synchronizer flops = 0.
- **Reset mid-frame:** the partial frame is discarded. The next frame must start with a new `load` falling edge.
- The outputs are pure register values. Decode-mode interpretation (Code-B font) is left to consumers.

## Timing
- Latency from the `load` rising edge at the pin to the register update and `frame_valid`: 4 `clk` cycles (2 synchronizer, 1 edge detect, 1 register write). All updated registers and the pulse change in the same cycle.
- Input requirements:
  - `sclk` high time ≥ 3 `clk` periods and low time ≥ 3 `clk` periods;
  - `sdi` stable ≥ 3 `clk` periods around each `sclk` rise;
  - `load` high time ≥ 3 `clk` periods between frames.
- `frame_valid` and `frame_err` are exclusive and each lasts exactly one cycle per commit.
- Back-to-back frames are supported at the minimum `load` high time; there is no backpressure.

## Configuration
- `SSEG_RX_LEN_CHECK_EN` defined:
  - a commit with `bcnt` ≠ 16 updates no register and pulses `frame_err` in place of `frame_valid`;
  - `bcnt` > 16 counts as an error (saturated count).
- Not defined:
  - the last 16 shifted bits are always committed and `frame_valid` pulses;
  - `frame_err` is tied to 0 and `bcnt` is not implemented.

## Structure
- `sseg_pkg` holds:
  - address constants `ADDR_NOOP`, `ADDR_DIG0` … `ADDR_DIG7`, `ADDR_DECODE`, `ADDR_INTENS`, `ADDR_SCAN`, `ADDR_SHDN`, `ADDR_TEST`;
  - `FRAME_W`;
  - the reset values.
- One sub-module, `sync_edge`: a 2-flop synchronizer plus delay flop with `rise` and `fall` outputs, instantiated three times.

## Test plan
- **Reset then frame 0x0C01:** after reset, all outputs = 0 (`shutdown_n` = 0). Send 0x0C01 → `shutdown_n` = 1 and `frame_valid` pulses exactly 4 cycles after the `load` rise.
- **Digit addressing:** 0x017E → `seg[7:0]` = 0x7E, all other bits 0. Then 0x0870 → `seg[63:56]` = 0x70 and `seg[7:0]` still 0x7E.
- **Control registers:** 0x0A0F → `intensity` = 0xF; 0x0B05 → `scan_limit` = 5; 0x09FF → `decode_mode` = 0xFF; 0x0F01 → `disp_test` = 1; 0x0055 → no register change with one `frame_valid`.
- **Length checking:** 15-bit frame 0x017E with `SSEG_RX_LEN_CHECK_EN` → `frame_err` pulse and `seg` unchanged. Without the macro → frame commits.
- **Ignored edges:** extra `sclk` pulses while `load` is high → no change. `sclk` and `load` rising together → the pre-edge frame commits.
- **Reset mid-frame:** assert `rst` after 8 bits of 0x0312 → all outputs return to their reset values. Full 0x0312 afterwards → `seg[23:16]` = 0x12.

Source files
------------

// File: rtl/sseg_spi_rx_pkg.sv
// Shared constants for the seven-segment serial receiver: frame addresses,
// register reset values and the synchronizer lane indices.
package sseg_pkg;

    localparam int FRAME_W = 16;
    localparam int BCNT_W  = 5;

    typedef logic [3:0] addr_t;

    localparam addr_t ADDR_NOOP   = 4'h0;
    localparam addr_t ADDR_DIG0   = 4'h1;
    localparam addr_t ADDR_DIG1   = 4'h2;
    localparam addr_t ADDR_DIG2   = 4'h3;
    localparam addr_t ADDR_DIG3   = 4'h4;
    localparam addr_t ADDR_DIG4   = 4'h5;
    localparam addr_t ADDR_DIG5   = 4'h6;
    localparam addr_t ADDR_DIG6   = 4'h7;
    localparam addr_t ADDR_DIG7   = 4'h8;
    localparam addr_t ADDR_DECODE = 4'h9;
    localparam addr_t ADDR_INTENS = 4'hA;
    localparam addr_t ADDR_SCAN   = 4'hB;
    localparam addr_t ADDR_SHDN   = 4'hC;
    localparam addr_t ADDR_TEST   = 4'hF;

    typedef enum logic [1:0] {
        SYNC_SDI  = 2'd0,
        SYNC_SCLK = 2'd1,
        SYNC_LOAD = 2'd2
    } sync_idx_e;

    typedef struct packed {
        logic [7:0] decode_mode;
        logic [3:0] intensity;
        logic [2:0] scan_limit;
        logic       shutdown_n;
        logic       disp_test;
    } ctrl_t;

    localparam logic [7:0] RST_DIGIT = 8'h00;
    // Display comes out of reset in shutdown.
    localparam ctrl_t CTRL_RST = '{
        decode_mode: 8'h00,
        intensity:   4'h0,
        scan_limit:  3'h0,
        shutdown_n:  1'b0,
        disp_test:   1'b0
    };

endpackage

// File: rtl/sseg_spi_rx_if.sv
// Display link bundle: 3-wire serial inputs plus the decoded register image.
interface sseg_spi_rx_if #(
    parameter int DIGITS = 8
);
    logic                  sclk;
    logic                  load;
    logic                  sdi;
    logic [8*DIGITS-1:0]   seg;
    logic [7:0]            decode_mode;
    logic [3:0]            intensity;
    logic [2:0]            scan_limit;
    logic                  shutdown_n;
    logic                  disp_test;
    logic                  frame_valid;
    logic                  frame_err;

    modport master (
        output sclk, load, sdi,
        input  seg, decode_mode, intensity, scan_limit, shutdown_n,
               disp_test, frame_valid, frame_err
    );

    modport slave (
        input  sclk, load, sdi,
        output seg, decode_mode, intensity, scan_limit, shutdown_n,
               disp_test, frame_valid, frame_err
    );
endinterface

// File: rtl/sseg_spi_rx_sync_edge.sv
// Two-flop synchronizer plus delay flop; level and edge outputs are registered
// together so they stay cycle-aligned with each other.
module sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic lvl_o,
    output logic rise_o,
    output logic fall_o
);
    logic [1:0] sync_q;
    logic       dly_q;
    logic       rise_q;
    logic       fall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b00;
            dly_q  <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], d_i};
            dly_q  <= sync_q[1];
            rise_q <= sync_q[1] & ~dly_q;
            fall_q <= ~sync_q[1] & dly_q;
        end
    end

    assign lvl_o  = dly_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;
endmodule

// File: rtl/sseg_spi_rx.sv
// Seven-segment serial link receiver: oversamples sclk/load/sdi, shifts frames
// MSB-first, decodes on load rise. Optional length check: SSEG_RX_LEN_CHECK_EN.
module sseg_spi_rx
    import sseg_pkg::*;
#(
    parameter int FRAME_W = 16,
    parameter int DIGITS  = 8
) (
    input  logic         clk,
    input  logic         rst,
    sseg_spi_rx_if.slave bus
);
    logic [2:0] pin_w;
    logic [2:0] lvl_w;
    logic [2:0] rise_w;
    logic [2:0] fall_w;

    assign pin_w[SYNC_SDI]  = bus.sdi;
    assign pin_w[SYNC_SCLK] = bus.sclk;
    assign pin_w[SYNC_LOAD] = bus.load;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_sync
            sync_edge u_sync (
                .clk    (clk),
                .rst    (rst),
                .d_i    (pin_w[gi]),
                .lvl_o  (lvl_w[gi]),
                .rise_o (rise_w[gi]),
                .fall_o (fall_w[gi])
            );
        end
    endgenerate

    // load level is already high in the commit cycle, so a coincident sclk
    // rise is dropped and the commit sees the pre-edge shift register.
    logic shift_en_w;
    logic commit_w;
    logic accept_w;
    assign shift_en_w = rise_w[SYNC_SCLK] & ~lvl_w[SYNC_LOAD];
    assign commit_w   = rise_w[SYNC_LOAD];

    logic [FRAME_W-1:0] sr_q, sr_d;
    ctrl_t              ctrl_q, ctrl_d;
    logic               fv_q, fv_d;
    addr_t              addr_w;
    logic [7:0]         data_w;

    assign addr_w = sr_q[11:8];
    assign data_w = sr_q[7:0];

`ifdef SSEG_RX_LEN_CHECK_EN
    logic [BCNT_W-1:0] bcnt_q, bcnt_d;
    logic              fe_q, fe_d;

    always_comb begin
        bcnt_d = bcnt_q;
        if (fall_w[SYNC_LOAD]) begin
            bcnt_d = '0;
        end else if (shift_en_w && (bcnt_q != '1)) begin
            bcnt_d = bcnt_q + 1'b1;
        end
    end

    assign accept_w = commit_w && (bcnt_q == BCNT_W'(FRAME_W));
    assign fe_d     = commit_w && !accept_w;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcnt_q <= '0;
            fe_q   <= 1'b0;
        end else begin
            bcnt_q <= bcnt_d;
            fe_q   <= fe_d;
        end
    end

    assign bus.frame_err = fe_q;

    logic unused_w;
    assign unused_w = ^{lvl_w[SYNC_SCLK], fall_w[SYNC_SCLK], rise_w[SYNC_SDI],
                        fall_w[SYNC_SDI], sr_q[FRAME_W-1]};
`else
    assign accept_w      = commit_w;
    assign bus.frame_err = 1'b0;

    logic unused_w;
    assign unused_w = ^{lvl_w[SYNC_SCLK], fall_w[SYNC_SCLK], rise_w[SYNC_SDI],
                        fall_w[SYNC_SDI], fall_w[SYNC_LOAD], sr_q[FRAME_W-1]};
`endif

    always_comb begin
        sr_d   = sr_q;
        ctrl_d = ctrl_q;
        fv_d   = accept_w;
        if (shift_en_w) begin
            sr_d = {sr_q[FRAME_W-2:0], lvl_w[SYNC_SDI]};
        end
        if (accept_w) begin
            case (addr_w)
                ADDR_DECODE: ctrl_d.decode_mode = data_w;
                ADDR_INTENS: ctrl_d.intensity   = data_w[3:0];
                ADDR_SCAN:   ctrl_d.scan_limit  = data_w[2:0];
                ADDR_SHDN:   ctrl_d.shutdown_n  = data_w[0];
                ADDR_TEST:   ctrl_d.disp_test   = data_w[0];
                default:     ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q   <= '0;
            ctrl_q <= CTRL_RST;
            fv_q   <= 1'b0;
        end else begin
            sr_q   <= sr_d;
            ctrl_q <= ctrl_d;
            fv_q   <= fv_d;
        end
    end

    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            logic [7:0] dig_q, dig_d;
            assign dig_d = (accept_w && (addr_w == addr_t'(int'(ADDR_DIG0) + gi)))
                         ? data_w : dig_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    dig_q <= RST_DIGIT;
                end else begin
                    dig_q <= dig_d;
                end
            end
            assign bus.seg[8*gi +: 8] = dig_q;
        end
    endgenerate

    assign bus.decode_mode = ctrl_q.decode_mode;
    assign bus.intensity   = ctrl_q.intensity;
    assign bus.scan_limit  = ctrl_q.scan_limit;
    assign bus.shutdown_n  = ctrl_q.shutdown_n;
    assign bus.disp_test   = ctrl_q.disp_test;
    assign bus.frame_valid = fv_q;
endmodule
